// File: rtl/axi_obi_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : axi_obi_bridge                                            |
// | Purpose  : AXI4 slave (32-bit) to OBI master bridge. One AXI         |
// |            transaction at a time, INCR/FIXED bursts, one OBI request |
// |            outstanding, OBI errors reported as SLVERR.               |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module axi_obi_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  aw_valid_i,
  output logic                  aw_ready_o,
  input  logic [ID_WIDTH-1:0]   aw_id_i,
  input  logic [ADDR_WIDTH-1:0] aw_addr_i,
  input  logic [7:0]            aw_len_i,
  input  logic [2:0]            aw_size_i,
  input  logic [1:0]            aw_burst_i,
  input  logic                  w_valid_i,
  output logic                  w_ready_o,
  input  logic [DATA_WIDTH-1:0] w_data_i,
  input  logic [3:0]            w_strb_i,
  input  logic                  w_last_i,
  output logic                  b_valid_o,
  input  logic                  b_ready_i,
  output logic [ID_WIDTH-1:0]   b_id_o,
  output logic [1:0]            b_resp_o,
  input  logic                  ar_valid_i,
  output logic                  ar_ready_o,
  input  logic [ID_WIDTH-1:0]   ar_id_i,
  input  logic [ADDR_WIDTH-1:0] ar_addr_i,
  input  logic [7:0]            ar_len_i,
  input  logic [2:0]            ar_size_i,
  input  logic [1:0]            ar_burst_i,
  output logic                  r_valid_o,
  input  logic                  r_ready_i,
  output logic [ID_WIDTH-1:0]   r_id_o,
  output logic [DATA_WIDTH-1:0] r_data_o,
  output logic [1:0]            r_resp_o,
  output logic                  r_last_o,
  output logic                  obi_req_o,
  input  logic                  obi_gnt_i,
  output logic [ADDR_WIDTH-1:0] obi_addr_o,
  output logic                  obi_we_o,
  output logic [3:0]            obi_be_o,
  output logic [DATA_WIDTH-1:0] obi_wdata_o,
  input  logic                  obi_rvalid_i,
  input  logic [DATA_WIDTH-1:0] obi_rdata_i,
  input  logic                  obi_err_i
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_DATA = 3'd1,
    WR_REQ  = 3'd2,
    WR_WAIT = 3'd3,
    WR_RESP = 3'd4,
    RD_REQ  = 3'd5,
    RD_WAIT = 3'd6,
    RD_RESP = 3'd7
  } state_t;

  localparam logic [1:0]            c_resp_okay   = 2'b00;
  localparam logic [1:0]            c_resp_slverr = 2'b10;
  localparam logic [ADDR_WIDTH-3:0] c_word_inc    = {{(ADDR_WIDTH-3){1'b0}}, 1'b1};

  state_t                r_state;
  state_t                w_state_next;
  logic [7:0]            r_len;
  logic [7:0]            r_beat;
  logic                  r_fixed;
  logic                  r_err;
  logic                  r_prio_write;
  logic                  w_pick_write;
  logic                  w_last_beat;
  logic                  w_err_next;
  logic [ADDR_WIDTH-1:0] w_addr_adv;

  // Beat size and WLAST carry no information for a 32-bit-only, len-driven bridge.
  logic w_unused;
  assign w_unused = ^{aw_size_i, ar_size_i, w_last_i};

  assign w_last_beat = (r_beat == r_len);
  assign w_err_next  = r_err | (obi_rvalid_i & obi_err_i);
  // Bursts after the first beat are word aligned; FIXED keeps the address.
  assign w_addr_adv  = r_fixed ? obi_addr_o
                               : {obi_addr_o[ADDR_WIDTH-1:2] + c_word_inc, 2'b00};

  // Channel selection in IDLE: a lone valid wins, otherwise the kind not served last.
  always_comb begin
    w_pick_write = r_prio_write;
    if (aw_valid_i && !ar_valid_i) begin
      w_pick_write = 1'b1;
    end else if (ar_valid_i && !aw_valid_i) begin
      w_pick_write = 1'b0;
    end
  end

  // Next-state decode; every transition is qualified by a completed handshake.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (aw_valid_i && aw_ready_o)      w_state_next = WR_DATA;
        else if (ar_valid_i && ar_ready_o) w_state_next = RD_REQ;
      end
      WR_DATA: if (w_valid_i && w_ready_o)   w_state_next = WR_REQ;
      WR_REQ:  if (obi_gnt_i)                w_state_next = WR_WAIT;
      WR_WAIT: if (obi_rvalid_i)             w_state_next = w_last_beat ? WR_RESP : WR_DATA;
      WR_RESP: if (b_ready_i)                w_state_next = IDLE;
      RD_REQ:  if (obi_gnt_i)                w_state_next = RD_WAIT;
      RD_WAIT: if (obi_rvalid_i)             w_state_next = RD_RESP;
      RD_RESP: if (r_ready_i)                w_state_next = r_last_o ? IDLE : RD_REQ;
      default:                               w_state_next = IDLE;
    endcase
  end

  // State register plus registered outputs, derived from the state being entered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= IDLE;
      r_len        <= '0;
      r_beat       <= '0;
      r_fixed      <= 1'b0;
      r_err        <= 1'b0;
      r_prio_write <= 1'b1;
      aw_ready_o   <= 1'b0;
      ar_ready_o   <= 1'b0;
      w_ready_o    <= 1'b0;
      b_valid_o    <= 1'b0;
      b_id_o       <= '0;
      b_resp_o     <= c_resp_okay;
      r_valid_o    <= 1'b0;
      r_id_o       <= '0;
      r_data_o     <= '0;
      r_resp_o     <= c_resp_okay;
      r_last_o     <= 1'b0;
      obi_req_o    <= 1'b0;
      obi_addr_o   <= '0;
      obi_we_o     <= 1'b0;
      obi_be_o     <= '0;
      obi_wdata_o  <= '0;
    end else begin
      r_state    <= w_state_next;
      aw_ready_o <= (w_state_next == IDLE) &&  w_pick_write;
      ar_ready_o <= (w_state_next == IDLE) && !w_pick_write;
      w_ready_o  <= (w_state_next == WR_DATA);
      obi_req_o  <= (w_state_next == WR_REQ) || (w_state_next == RD_REQ);
      b_valid_o  <= (w_state_next == WR_RESP);
      r_valid_o  <= (w_state_next == RD_RESP);
      case (r_state)
        IDLE: begin
          if (aw_valid_i && aw_ready_o) begin
            b_id_o       <= aw_id_i;
            obi_addr_o   <= aw_addr_i;
            r_len        <= aw_len_i;
            r_fixed      <= (aw_burst_i == 2'b00);
            r_beat       <= '0;
            r_err        <= 1'b0;
            obi_we_o     <= 1'b1;
            r_prio_write <= 1'b0;
          end else if (ar_valid_i && ar_ready_o) begin
            r_id_o       <= ar_id_i;
            obi_addr_o   <= ar_addr_i;
            r_len        <= ar_len_i;
            r_fixed      <= (ar_burst_i == 2'b00);
            r_beat       <= '0;
            r_err        <= 1'b0;
            obi_we_o     <= 1'b0;
            obi_be_o     <= 4'hF;
            r_prio_write <= 1'b1;
          end
        end
        WR_DATA: begin
          if (w_valid_i && w_ready_o) begin
            obi_wdata_o <= w_data_i;
            obi_be_o    <= w_strb_i;
          end
        end
        WR_WAIT: begin
          if (obi_rvalid_i) begin
            r_err <= w_err_next;
            if (w_last_beat) begin
              b_resp_o <= w_err_next ? c_resp_slverr : c_resp_okay;
            end else begin
              obi_addr_o <= w_addr_adv;
              r_beat     <= r_beat + 8'd1;
            end
          end
        end
        RD_WAIT: begin
          if (obi_rvalid_i) begin
            r_data_o <= obi_rdata_i;
            r_resp_o <= obi_err_i ? c_resp_slverr : c_resp_okay;
            r_last_o <= w_last_beat;
          end
        end
        RD_RESP: begin
          if (r_ready_i && !r_last_o) begin
            obi_addr_o <= w_addr_adv;
            r_beat     <= r_beat + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_obi_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_axi_obi_bridge                                         |
// | Purpose  : Directed self-checking bench for axi_obi_bridge with a    |
// |            small OBI memory responder and request log.               |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_axi_obi_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        aw_valid = 1'b0, aw_ready;
  logic [1:0]  aw_id = '0;
  logic [31:0] aw_addr = '0;
  logic [7:0]  aw_len = '0;
  logic [2:0]  aw_size = 3'd2;
  logic [1:0]  aw_burst = 2'b01;
  logic        w_valid = 1'b0, w_ready;
  logic [31:0] w_data = '0;
  logic [3:0]  w_strb = '0;
  logic        w_last = 1'b0;
  logic        b_valid, b_ready = 1'b1;
  logic [1:0]  b_id, b_resp;
  logic        ar_valid = 1'b0, ar_ready;
  logic [1:0]  ar_id = '0;
  logic [31:0] ar_addr = '0;
  logic [7:0]  ar_len = '0;
  logic [2:0]  ar_size = 3'd2;
  logic [1:0]  ar_burst = 2'b01;
  logic        r_valid, r_ready = 1'b1;
  logic [1:0]  r_id, r_resp;
  logic [31:0] r_data;
  logic        r_last;
  logic        obi_req, obi_we;
  logic        obi_gnt = 1'b0, obi_rvalid = 1'b0, obi_err = 1'b0;
  logic [31:0] obi_addr, obi_wdata;
  logic [31:0] obi_rdata = '0;
  logic [3:0]  obi_be;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  axi_obi_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(2)) dut (
    .clk_i(clk), .rst_i(rst),
    .aw_valid_i(aw_valid), .aw_ready_o(aw_ready), .aw_id_i(aw_id), .aw_addr_i(aw_addr),
    .aw_len_i(aw_len), .aw_size_i(aw_size), .aw_burst_i(aw_burst),
    .w_valid_i(w_valid), .w_ready_o(w_ready), .w_data_i(w_data), .w_strb_i(w_strb),
    .w_last_i(w_last),
    .b_valid_o(b_valid), .b_ready_i(b_ready), .b_id_o(b_id), .b_resp_o(b_resp),
    .ar_valid_i(ar_valid), .ar_ready_o(ar_ready), .ar_id_i(ar_id), .ar_addr_i(ar_addr),
    .ar_len_i(ar_len), .ar_size_i(ar_size), .ar_burst_i(ar_burst),
    .r_valid_o(r_valid), .r_ready_i(r_ready), .r_id_o(r_id), .r_data_o(r_data),
    .r_resp_o(r_resp), .r_last_o(r_last),
    .obi_req_o(obi_req), .obi_gnt_i(obi_gnt), .obi_addr_o(obi_addr), .obi_we_o(obi_we),
    .obi_be_o(obi_be), .obi_wdata_o(obi_wdata), .obi_rvalid_i(obi_rvalid),
    .obi_rdata_i(obi_rdata), .obi_err_i(obi_err)
  );

  // OBI responder: grant after gnt_delay cycles, respond resp_delay cycles after grant.
  int          gnt_delay = 0;
  int          resp_delay = 0;
  logic [31:0] rd_tbl  [64];
  logic        err_tbl [64];
  logic [31:0] log_addr[64];
  logic [31:0] log_wd  [64];
  logic        log_we  [64];
  logic [3:0]  log_be  [64];
  int          log_n = 0;
  int          m_cnt = 0, m_pcnt = 0, m_pidx = 0;
  logic        m_pend = 1'b0, m_acc = 1'b0;
  logic [31:0] s_addr = '0, s_wd = '0;
  logic        s_we = 1'b0;
  logic [3:0]  s_be = '0;

  // Responder process, acting just after each rising edge.
  always begin
    @(posedge clk);
    #1;
    if (rst) begin
      m_pend = 1'b0; m_acc = 1'b0; m_cnt = 0;
      obi_gnt = 1'b0; obi_rvalid = 1'b0; obi_err = 1'b0; obi_rdata = '0;
    end else begin
      if (m_acc && log_n < 64) begin
        log_addr[log_n] = s_addr; log_we[log_n] = s_we;
        log_be[log_n] = s_be; log_wd[log_n] = s_wd;
        m_pidx = log_n; log_n++;
        m_pend = 1'b1; m_pcnt = resp_delay;
      end
      m_acc = 1'b0;
      obi_rvalid = 1'b0; obi_err = 1'b0; obi_rdata = '0;
      if (m_pend) begin
        if (m_pcnt == 0) begin
          obi_rvalid = 1'b1; obi_rdata = rd_tbl[m_pidx]; obi_err = err_tbl[m_pidx];
          m_pend = 1'b0;
        end else begin
          m_pcnt--;
        end
      end
      obi_gnt = 1'b0;
      if (obi_req) begin
        if (m_cnt >= gnt_delay) begin
          obi_gnt = 1'b1; m_acc = 1'b1; m_cnt = 0;
          s_addr = obi_addr; s_we = obi_we; s_be = obi_be; s_wd = obi_wdata;
        end else begin
          m_cnt++;
        end
      end else begin
        m_cnt = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic aw_send(input logic [1:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [1:0] burst);
    aw_id = id; aw_addr = addr; aw_len = len; aw_burst = burst; aw_valid = 1'b1;
    for (int i = 0; i < 60 && !aw_ready; i++) @(negedge clk);
    chk("aw_accept", {31'd0, aw_ready}, 32'd1);
    @(negedge clk);
    aw_valid = 1'b0;
  endtask

  task automatic ar_send(input logic [1:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [1:0] burst);
    ar_id = id; ar_addr = addr; ar_len = len; ar_burst = burst; ar_valid = 1'b1;
    for (int i = 0; i < 60 && !ar_ready; i++) @(negedge clk);
    chk("ar_accept", {31'd0, ar_ready}, 32'd1);
    @(negedge clk);
    ar_valid = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] data, input logic [3:0] strb);
    w_data = data; w_strb = strb; w_valid = 1'b1;
    for (int i = 0; i < 60 && !w_ready; i++) @(negedge clk);
    chk("w_accept", {31'd0, w_ready}, 32'd1);
    @(negedge clk);
    w_valid = 1'b0;
  endtask

  task automatic b_recv(input string tag, input logic [1:0] id, input logic [1:0] resp);
    for (int i = 0; i < 60 && !b_valid; i++) @(negedge clk);
    chk({tag, "_bvalid"}, {31'd0, b_valid}, 32'd1);
    chk({tag, "_bid"}, {30'd0, b_id}, {30'd0, id});
    chk({tag, "_bresp"}, {30'd0, b_resp}, {30'd0, resp});
    @(negedge clk);
  endtask

  task automatic r_recv(input string tag, input logic [1:0] id, input logic [31:0] data,
                        input logic [1:0] resp, input logic last);
    for (int i = 0; i < 60 && !r_valid; i++) @(negedge clk);
    chk({tag, "_rvalid"}, {31'd0, r_valid}, 32'd1);
    chk({tag, "_rid"}, {30'd0, r_id}, {30'd0, id});
    chk({tag, "_rdata"}, r_data, data);
    chk({tag, "_rresp"}, {30'd0, r_resp}, {30'd0, resp});
    chk({tag, "_rlast"}, {31'd0, r_last}, {31'd0, last});
    @(negedge clk);
  endtask

  // Directed sequence.
  initial begin
    int          base;
    int          base2;
    logic        seen;
    logic [3:0]  ebe [4];
    logic [31:0] ewd [4];
    for (int i = 0; i < 64; i++) begin
      rd_tbl[i] = '0; err_tbl[i] = 1'b0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_aw_ready", {31'd0, aw_ready}, 32'd0);
    chk("rst_ar_ready", {31'd0, ar_ready}, 32'd0);
    chk("rst_w_ready",  {31'd0, w_ready},  32'd0);
    chk("rst_obi_req",  {31'd0, obi_req},  32'd0);
    chk("rst_r_valid",  {31'd0, r_valid},  32'd0);
    chk("rst_b_valid",  {31'd0, b_valid},  32'd0);
    chk("rst_r_data",   r_data,            32'd0);
    chk("rst_obi_addr", obi_addr,          32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_aw_ready", {31'd0, aw_ready}, 32'd1);
    chk("idle_ar_ready", {31'd0, ar_ready}, 32'd0);

    // Arbitration after reset: write first, then read
    base = log_n;
    rd_tbl[base+1] = 32'hA5A5_0001;
    aw_id = 2'd0; aw_addr = 32'h8000_0100; aw_len = 8'd0; aw_burst = 2'b01; aw_valid = 1'b1;
    ar_id = 2'd3; ar_addr = 32'h8000_0200; ar_len = 8'd0; ar_burst = 2'b01; ar_valid = 1'b1;
    chk("arb1_aw_sel", {31'd0, aw_ready}, 32'd1);
    chk("arb1_ar_sel", {31'd0, ar_ready}, 32'd0);
    @(negedge clk);
    aw_valid = 1'b0;
    chk("arb1_ar_busy", {31'd0, ar_ready}, 32'd0);
    w_send(32'h1111_2222, 4'hF);
    b_recv("arb1", 2'd0, 2'b00);
    for (int i = 0; i < 60 && !ar_ready; i++) @(negedge clk);
    chk("arb1_ar_accept", {31'd0, ar_ready}, 32'd1);
    @(negedge clk);
    ar_valid = 1'b0;
    r_recv("arb1", 2'd3, 32'hA5A5_0001, 2'b00, 1'b1);
    chk("arb1_first_we",   {31'd0, log_we[base]},   32'd1);
    chk("arb1_second_we",  {31'd0, log_we[base+1]}, 32'd0);
    chk("arb1_read_addr",  log_addr[base+1], 32'h8000_0200);

    // Single read with a 2-cycle grant delay
    base = log_n;
    gnt_delay = 2;
    rd_tbl[base] = 32'hDEAD_BEEF;
    ar_send(2'd1, 32'h8000_0010, 8'd0, 2'b01);
    r_recv("rd1", 2'd1, 32'hDEAD_BEEF, 2'b00, 1'b1);
    chk("rd1_nreq", log_n - base, 32'd1);
    chk("rd1_addr", log_addr[base], 32'h8000_0010);
    chk("rd1_we",   {31'd0, log_we[base]}, 32'd0);
    chk("rd1_be",   {28'd0, log_be[base]}, 32'h0000_000F);
    gnt_delay = 0;

    // INCR write burst of 4 with a partial strobe on beat 1
    base = log_n;
    ebe = '{4'hF, 4'h3, 4'hF, 4'hF};
    ewd = '{32'hC0DE_0000, 32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003};
    aw_send(2'd2, 32'h8000_0000, 8'd3, 2'b01);
    for (int k = 0; k < 4; k++) w_send(ewd[k], ebe[k]);
    b_recv("wr4", 2'd2, 2'b00);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      seen = seen | b_valid;
      @(negedge clk);
    end
    chk("wr4_single_b", {31'd0, seen}, 32'd0);
    chk("wr4_nreq", log_n - base, 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk("wr4_addr",  log_addr[base+k], 32'h8000_0000 + 32'(4 * k));
      chk("wr4_be",    {28'd0, log_be[base+k]}, {28'd0, ebe[k]});
      chk("wr4_we",    {31'd0, log_we[base+k]}, 32'd1);
      chk("wr4_wdata", log_wd[base+k], ewd[k]);
    end

    // Arbitration again: write was served last, so the read wins
    base = log_n;
    rd_tbl[base] = 32'hCAFE_0002;
    aw_id = 2'd1; aw_addr = 32'h8000_0300; aw_len = 8'd0; aw_burst = 2'b01; aw_valid = 1'b1;
    ar_id = 2'd2; ar_addr = 32'h8000_0400; ar_len = 8'd0; ar_burst = 2'b01; ar_valid = 1'b1;
    chk("arb2_ar_sel", {31'd0, ar_ready}, 32'd1);
    chk("arb2_aw_sel", {31'd0, aw_ready}, 32'd0);
    @(negedge clk);
    ar_valid = 1'b0;
    r_recv("arb2", 2'd2, 32'hCAFE_0002, 2'b00, 1'b1);
    for (int i = 0; i < 60 && !aw_ready; i++) @(negedge clk);
    chk("arb2_aw_accept", {31'd0, aw_ready}, 32'd1);
    @(negedge clk);
    aw_valid = 1'b0;
    w_send(32'h3333_4444, 4'hC);
    b_recv("arb2", 2'd1, 2'b00);
    chk("arb2_first_we",  {31'd0, log_we[base]},   32'd0);
    chk("arb2_second_we", {31'd0, log_we[base+1]}, 32'd1);
    chk("arb2_wr_addr",   log_addr[base+1], 32'h8000_0300);
    chk("arb2_wr_be",     {28'd0, log_be[base+1]}, 32'h0000_000C);

    // 2-beat read, unaligned start, error on beat 1
    base = log_n;
    rd_tbl[base] = 32'h1000_0000; rd_tbl[base+1] = 32'h1000_0001; err_tbl[base+1] = 1'b1;
    ar_send(2'd0, 32'h8000_0102, 8'd1, 2'b01);
    r_recv("rderr_b0", 2'd0, 32'h1000_0000, 2'b00, 1'b0);
    r_recv("rderr_b1", 2'd0, 32'h1000_0001, 2'b10, 1'b1);
    chk("rderr_addr0", log_addr[base],   32'h8000_0102);
    chk("rderr_addr1", log_addr[base+1], 32'h8000_0104);

    // 2-beat write, error on beat 0
    base = log_n;
    err_tbl[base] = 1'b1;
    aw_send(2'd3, 32'h8000_0500, 8'd1, 2'b01);
    w_send(32'h5555_0000, 4'hF);
    w_send(32'h5555_0001, 4'hF);
    b_recv("wrerr", 2'd3, 2'b10);
    chk("wrerr_nreq", log_n - base, 32'd2);

    // R backpressure for 5 cycles
    base = log_n;
    rd_tbl[base] = 32'hBBBB_0000; rd_tbl[base+1] = 32'hBBBB_0001;
    r_ready = 1'b0;
    ar_send(2'd1, 32'h8000_0600, 8'd1, 2'b01);
    for (int i = 0; i < 60 && !r_valid; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp_rvalid",  {31'd0, r_valid}, 32'd1);
      chk("bp_rdata",   r_data, 32'hBBBB_0000);
      chk("bp_obi_req", {31'd0, obi_req}, 32'd0);
      @(negedge clk);
    end
    chk("bp_nreq", log_n - base, 32'd1);
    r_ready = 1'b1;
    r_recv("bp_b0", 2'd1, 32'hBBBB_0000, 2'b00, 1'b0);
    r_recv("bp_b1", 2'd1, 32'hBBBB_0001, 2'b00, 1'b1);

    // FIXED burst of 3
    base = log_n;
    rd_tbl[base] = 32'hF0; rd_tbl[base+1] = 32'hF1; rd_tbl[base+2] = 32'hF2;
    ar_send(2'd0, 32'h8000_0040, 8'd2, 2'b00);
    r_recv("fix_b0", 2'd0, 32'hF0, 2'b00, 1'b0);
    r_recv("fix_b1", 2'd0, 32'hF1, 2'b00, 1'b0);
    r_recv("fix_b2", 2'd0, 32'hF2, 2'b00, 1'b1);
    for (int k = 0; k < 3; k++) chk("fix_addr", log_addr[base+k], 32'h8000_0040);

    // Reset during RD_WAIT of beat 1 of a 4-beat read
    base = log_n;
    resp_delay = 3;
    rd_tbl[base] = 32'h7777_0000; rd_tbl[base+1] = 32'h7777_0001;
    ar_send(2'd2, 32'h8000_0700, 8'd3, 2'b01);
    r_recv("rst_b0", 2'd2, 32'h7777_0000, 2'b00, 1'b0);
    for (int i = 0; i < 60 && log_n < base + 2; i++) @(negedge clk);
    chk("rst_beat1_granted", log_n - base, 32'd2);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_r_valid",  {31'd0, r_valid},  32'd0);
    chk("mid_rst_obi_req",  {31'd0, obi_req},  32'd0);
    chk("mid_rst_ar_ready", {31'd0, ar_ready}, 32'd0);
    chk("mid_rst_aw_ready", {31'd0, aw_ready}, 32'd0);
    chk("mid_rst_b_valid",  {31'd0, b_valid},  32'd0);
    rst = 1'b0;
    resp_delay = 0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      seen = seen | r_valid | obi_req;
    end
    chk("post_rst_quiet", {31'd0, seen}, 32'd0);
    base2 = log_n;
    rd_tbl[base2] = 32'h1234_5678;
    ar_send(2'd3, 32'h8000_0800, 8'd0, 2'b01);
    r_recv("post_rst", 2'd3, 32'h1234_5678, 2'b00, 1'b1);
    chk("post_rst_addr", log_addr[base2], 32'h8000_0800);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
